cdb_broadcast_arbiter: RTL and testbench
========================================

Name: cdb_broadcast_arbiter

Overview:
- Transmitter side of the common data bus. Collects completed results from the ALU and branch execution units, buffers them in one FIFO per source, and round-robin arbitrates between the two.
- Drives exactly one registered broadcast per cycle to every bus listener: reorder buffer and reservation stations.
- Sits between the functional units and the listeners. Its outputs are the validBroadcast/robEntry/result fields listeners snoop for wakeup.

Parameters:
- WIDTH, 31: MSB index of data/PC fields (data is WIDTH+1 bits).
- ROB, 2: MSB index of the ROB tag.
- FIFO_AW, 1: FIFO address bits. Each source FIFO holds 2^FIFO_AW entries.

Ports:
- clk  input  1  clock, all state on rising edge.
- globalReset  input  1  synchronous, active-high reset.
- clear  input  1  pipeline flush (commit-side controlFlow[0]). Synchronous.
- aluValid  input  1  ALU result offered.
- aluReady  output  1  ALU FIFO can accept. Equals !aluFull && !clear.
- aluRob  input  ROB+1  ROB tag of ALU result.
- aluResult  input  WIDTH+1  ALU result value.
- brValid  input  1  branch result offered.
- brReady  output  1  branch FIFO can accept. Equals !brFull && !clear.
- brRob  input  ROB+1  ROB tag of branch.
- brResult  input  WIDTH+1  link value (PC+4; 0 for conditional branches).
- brNextPC  input  WIDTH+1  resolved next PC.
- brMispredict  input  1  resolved PC differs from predicted PC.
- validBroadcast  output  1  broadcast valid, registered.
- robBroadcast  output  ROB+1  tag being broadcast.
- valueBroadcast  output  WIDTH+1  value being broadcast.
- nextPCBroadcast  output  WIDTH+1  resolved PC (0 for ALU results).
- mispredictBroadcast  output  1  mispredict flag (0 for ALU results).
- isBranchBroadcast  output  1  broadcast came from the branch source.
- aluCount  output  FIFO_AW+1  ALU FIFO occupancy.
- brCount  output  FIFO_AW+1  branch FIFO occupancy.

Behaviour:
- One clock; reset is synchronous and active-high. globalReset is sampled on the rising edge of clk.
- Reset values:
  - All broadcast outputs are 0.
  - Both FIFOs are empty, so counts are 0.
  - lastGrant = branch, so the ALU wins the first tie.
- Handshake: a transfer occurs on an edge where valid && ready. Ready depends only on full and clear, not on a same-cycle pop. A full FIFO therefore refuses even while popping.
- FIFOs:
  - Circular buffer with read/write pointers of FIFO_AW bits that wrap modulo 2^FIFO_AW.
  - A separate count of FIFO_AW+1 bits tracks occupancy. full = (count == 2^FIFO_AW); empty = (count == 0).
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
- Arbitration, evaluated every cycle on FIFO heads:
  - Neither FIFO non-empty: validBroadcast <= 0. The other broadcast fields hold their old values but are don't-care.
  - Exactly one FIFO non-empty: that FIFO is granted.
  - Both non-empty: grant the source != lastGrant.
  - On a grant: the head is popped, loaded into the broadcast registers with validBroadcast <= 1, and lastGrant <= granted source.
- Each accepted result is broadcast exactly once, holding validBroadcast high for one cycle. There is no back-pressure from listeners.
- Ordering: per-source FIFO order is preserved. Cross-source order follows round-robin.
- Latency (no bypass): accepted at edge N, earliest visible after edge N+1. With both FIFOs saturated, each source gets one broadcast every 2 cycles.
- ALU grants drive nextPCBroadcast = 0, mispredictBroadcast = 0, isBranchBroadcast = 0.
- clear:
  - Both FIFOs are emptied (pointers and counts to 0) and validBroadcast <= 0.
  - Inputs presented in the clear cycle are not accepted, since ready is low.
  - lastGrant is preserved.
- globalReset takes priority over clear and over any in-flight activity, including a mid-FIFO state.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined: on an edge where both FIFOs are empty and not clear, an offered input is loaded directly into the broadcast registers without being written to its FIFO. This gives latency 1: accepted at edge N, visible after edge N.
  - If both inputs are offered, the round-robin winner bypasses and updates lastGrant; the loser is enqueued.
  - If any FIFO is non-empty, normal FIFO path only.
- Undefined: no bypass; all results pass through the FIFOs with latency 2.

Test Plan:
- Reset, then ALU push rob=3 value=0x0000_00AA at edge 1 -> validBroadcast=1 robBroadcast=3 valueBroadcast=0xAA isBranchBroadcast=0 after edge 2 (after edge 1 with CDB_BYPASS_EN); low the following cycle.
- Both FIFOs holding one entry each after reset -> ALU broadcast first, then branch (rob=5, nextPC=0x0000_0040, mispredict=1) next cycle; lastGrant=branch afterwards.
- Push 2 ALU results with no grants possible (held by branch traffic) -> aluCount=2, aluReady=0; a third aluValid is not accepted until a pop is followed by the next edge.
- FIFO wrap: push/pop 5 ALU results continuously with FIFO_AW=1 -> broadcasts emerge in push order with tags 0,1,2,3,4, and aluCount never exceeds 2.
- Both FIFOs partly full, assert clear for 1 cycle with aluValid=1 -> no transfer that cycle, aluCount=brCount=0, validBroadcast=0 next cycle, and the dropped input is never broadcast.
- globalReset asserted while both FIFOs are full -> all outputs 0 and counts 0 next cycle; the next tie is granted to the ALU.

Source files
------------

// File: rtl/cdb_broadcast_arbiter.sv
// cdb_broadcast_arbiter: common data bus transmitter. Buffers ALU and branch
// results in one FIFO per source and broadcasts one registered result per
// cycle, round-robin between the two sources.
// Optional feature macro: CDB_BYPASS_EN (when defined, a result arriving while
// both FIFOs are empty skips its FIFO and is broadcast one cycle earlier).
module cdb_broadcast_arbiter #(
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int FIFO_AW = 1
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             clear,
  input  logic             aluValid,
  output logic             aluReady,
  input  logic [ROB:0]     aluRob,
  input  logic [WIDTH:0]   aluResult,
  input  logic             brValid,
  output logic             brReady,
  input  logic [ROB:0]     brRob,
  input  logic [WIDTH:0]   brResult,
  input  logic [WIDTH:0]   brNextPC,
  input  logic             brMispredict,
  output logic             validBroadcast,
  output logic [ROB:0]     robBroadcast,
  output logic [WIDTH:0]   valueBroadcast,
  output logic [WIDTH:0]   nextPCBroadcast,
  output logic             mispredictBroadcast,
  output logic             isBranchBroadcast,
  output logic [FIFO_AW:0] aluCount,
  output logic [FIFO_AW:0] brCount
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  typedef enum logic {SRC_ALU = 1'b0, SRC_BR = 1'b1} src_e;

  logic [ROB:0]   alu_rob_mem [DEPTH];
  logic [WIDTH:0] alu_res_mem [DEPTH];
  logic [ROB:0]   br_rob_mem  [DEPTH];
  logic [WIDTH:0] br_res_mem  [DEPTH];
  logic [WIDTH:0] br_pc_mem   [DEPTH];
  logic           br_mis_mem  [DEPTH];

  logic [FIFO_AW-1:0] alu_wr_ptr_q, alu_rd_ptr_q, br_wr_ptr_q, br_rd_ptr_q;
  logic [FIFO_AW:0]   alu_cnt_q, br_cnt_q;
  src_e               last_grant_q;

  logic           valid_q, mis_q, is_br_q;
  logic [ROB:0]   rob_q;
  logic [WIDTH:0] value_q, next_pc_q;

  logic alu_push, br_push, alu_wr, br_wr;
  logic grant_alu, grant_br, byp_alu, byp_br;

  // Ready depends only on occupancy and flush, never on a same-cycle pop.
  assign aluReady = (alu_cnt_q != FULL_CNT) && !clear;
  assign brReady  = (br_cnt_q  != FULL_CNT) && !clear;
  assign alu_push = aluValid && aluReady;
  assign br_push  = brValid  && brReady;

  // Round-robin grant on FIFO heads; optional bypass when both FIFOs are empty.
  always_comb begin
    alu_wr    = alu_push;
    br_wr     = br_push;
    grant_alu = 1'b0;
    grant_br  = 1'b0;
    byp_alu   = 1'b0;
    byp_br    = 1'b0;
    if (!clear) begin
      if ((alu_cnt_q != '0) && ((br_cnt_q == '0) || (last_grant_q == SRC_BR))) begin
        grant_alu = 1'b1;
      end else if (br_cnt_q != '0) begin
        grant_br = 1'b1;
`ifdef CDB_BYPASS_EN
      end else if (alu_push && (!br_push || (last_grant_q == SRC_BR))) begin
        byp_alu = 1'b1;
        alu_wr  = 1'b0;
      end else if (br_push) begin
        byp_br = 1'b1;
        br_wr  = 1'b0;
`endif
      end
    end
  end

  // FIFO storage writes; pointers and counts live in the control block below.
  always_ff @(posedge clk) begin
    if (alu_wr) begin
      alu_rob_mem[alu_wr_ptr_q] <= aluRob;
      alu_res_mem[alu_wr_ptr_q] <= aluResult;
    end
    if (br_wr) begin
      br_rob_mem[br_wr_ptr_q] <= brRob;
      br_res_mem[br_wr_ptr_q] <= brResult;
      br_pc_mem[br_wr_ptr_q]  <= brNextPC;
      br_mis_mem[br_wr_ptr_q] <= brMispredict;
    end
  end

  // Pointer/count bookkeeping, grant history and the broadcast registers.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      alu_wr_ptr_q <= '0;
      alu_rd_ptr_q <= '0;
      br_wr_ptr_q  <= '0;
      br_rd_ptr_q  <= '0;
      alu_cnt_q    <= '0;
      br_cnt_q     <= '0;
      last_grant_q <= SRC_BR;
      valid_q      <= 1'b0;
      rob_q        <= '0;
      value_q      <= '0;
      next_pc_q    <= '0;
      mis_q        <= 1'b0;
      is_br_q      <= 1'b0;
    end else if (clear) begin
      alu_wr_ptr_q <= '0;
      alu_rd_ptr_q <= '0;
      br_wr_ptr_q  <= '0;
      br_rd_ptr_q  <= '0;
      alu_cnt_q    <= '0;
      br_cnt_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      if (alu_wr)    alu_wr_ptr_q <= alu_wr_ptr_q + PTR_ONE;
      if (grant_alu) alu_rd_ptr_q <= alu_rd_ptr_q + PTR_ONE;
      if (br_wr)     br_wr_ptr_q  <= br_wr_ptr_q + PTR_ONE;
      if (grant_br)  br_rd_ptr_q  <= br_rd_ptr_q + PTR_ONE;
      if (alu_wr && !grant_alu)      alu_cnt_q <= alu_cnt_q + CNT_ONE;
      else if (!alu_wr && grant_alu) alu_cnt_q <= alu_cnt_q - CNT_ONE;
      if (br_wr && !grant_br)        br_cnt_q  <= br_cnt_q + CNT_ONE;
      else if (!br_wr && grant_br)   br_cnt_q  <= br_cnt_q - CNT_ONE;

      valid_q <= grant_alu || grant_br || byp_alu || byp_br;
      if (grant_alu || byp_alu) begin
        rob_q        <= grant_alu ? alu_rob_mem[alu_rd_ptr_q] : aluRob;
        value_q      <= grant_alu ? alu_res_mem[alu_rd_ptr_q] : aluResult;
        next_pc_q    <= '0;
        mis_q        <= 1'b0;
        is_br_q      <= 1'b0;
        last_grant_q <= SRC_ALU;
      end else if (grant_br || byp_br) begin
        rob_q        <= grant_br ? br_rob_mem[br_rd_ptr_q] : brRob;
        value_q      <= grant_br ? br_res_mem[br_rd_ptr_q] : brResult;
        next_pc_q    <= grant_br ? br_pc_mem[br_rd_ptr_q]  : brNextPC;
        mis_q        <= grant_br ? br_mis_mem[br_rd_ptr_q] : brMispredict;
        is_br_q      <= 1'b1;
        last_grant_q <= SRC_BR;
      end
    end
  end

  assign validBroadcast      = valid_q;
  assign robBroadcast        = rob_q;
  assign valueBroadcast      = value_q;
  assign nextPCBroadcast     = next_pc_q;
  assign mispredictBroadcast = mis_q;
  assign isBranchBroadcast   = is_br_q;
  assign aluCount            = alu_cnt_q;
  assign brCount             = br_cnt_q;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Testbench for cdb_broadcast_arbiter: queue-based reference model of the
// two source FIFOs and the round-robin broadcast, driven cycle by cycle.
module tb_cdb_broadcast_arbiter;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [2:0]  rob;
    logic [31:0] val;
    logic [31:0] pc;
    logic        mis;
    logic        is_br;
  } ent_t;

  logic        clk = 1'b0;
  logic        globalReset, clear;
  logic        aluValid, aluReady, brValid, brReady, brMispredict;
  logic [2:0]  aluRob, brRob, robBroadcast;
  logic [31:0] aluResult, brResult, brNextPC;
  logic        validBroadcast, mispredictBroadcast, isBranchBroadcast;
  logic [31:0] valueBroadcast, nextPCBroadcast;
  logic [1:0]  aluCount, brCount;

  int checks = 0;
  int failures = 0;

  ent_t qa[$];
  ent_t qb[$];
  ent_t exp_e;
  bit   exp_valid;
  bit   exp_zero;
  bit   last_br;

  cdb_broadcast_arbiter dut (
    .clk(clk), .globalReset(globalReset), .clear(clear),
    .aluValid(aluValid), .aluReady(aluReady), .aluRob(aluRob), .aluResult(aluResult),
    .brValid(brValid), .brReady(brReady), .brRob(brRob), .brResult(brResult),
    .brNextPC(brNextPC), .brMispredict(brMispredict),
    .validBroadcast(validBroadcast), .robBroadcast(robBroadcast),
    .valueBroadcast(valueBroadcast), .nextPCBroadcast(nextPCBroadcast),
    .mispredictBroadcast(mispredictBroadcast), .isBranchBroadcast(isBranchBroadcast),
    .aluCount(aluCount), .brCount(brCount)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_valid = 1'b0;
    exp_zero  = 1'b1;
    exp_e     = '0;
    last_br   = 1'b1;
  endtask

  // Reference behaviour at one rising edge, using the inputs currently driven.
  task automatic model_edge();
    bit   acc_a, acc_b, pick_a;
    ent_t ea, eb;
    if (globalReset) begin
      model_reset();
      return;
    end
    if (clear) begin
      qa.delete();
      qb.delete();
      exp_valid = 1'b0;
      return;
    end
    acc_a = aluValid && (qa.size() < DEPTH);
    acc_b = brValid && (qb.size() < DEPTH);
    ea = '{rob: aluRob, val: aluResult, pc: 32'h0, mis: 1'b0, is_br: 1'b0};
    eb = '{rob: brRob, val: brResult, pc: brNextPC, mis: brMispredict, is_br: 1'b1};
    exp_valid = 1'b0;
    if (qa.size() != 0 || qb.size() != 0) begin
      pick_a = (qa.size() != 0) && (qb.size() == 0 || last_br);
      if (pick_a) exp_e = qa.pop_front();
      else        exp_e = qb.pop_front();
      exp_valid = 1'b1;
      last_br   = !pick_a;
    end
`ifdef CDB_BYPASS_EN
    else if (acc_a || acc_b) begin
      pick_a = acc_a && (!acc_b || last_br);
      if (pick_a) begin exp_e = ea; acc_a = 1'b0; end
      else        begin exp_e = eb; acc_b = 1'b0; end
      exp_valid = 1'b1;
      last_br   = !pick_a;
    end
`endif
    if (exp_valid) exp_zero = 1'b0;
    if (acc_a) qa.push_back(ea);
    if (acc_b) qb.push_back(eb);
  endtask

  // One cycle: drive at the falling edge, check state of the previous edge,
  // then advance the model across the next rising edge.
  task automatic cycle(input bit rst, input bit clr,
                       input bit av, input logic [2:0] arob, input logic [31:0] ares,
                       input bit bv, input logic [2:0] brob, input logic [31:0] bres,
                       input logic [31:0] bpc, input bit bmis);
    globalReset = rst; clear = clr;
    aluValid = av; aluRob = arob; aluResult = ares;
    brValid = bv; brRob = brob; brResult = bres; brNextPC = bpc; brMispredict = bmis;
    #1;
    checks++;
    if (aluReady !== ((qa.size() < DEPTH) && !clr)) begin
      failures++;
      $display("FAIL aluReady got=%b exp=%b", aluReady, (qa.size() < DEPTH) && !clr);
    end
    checks++;
    if (brReady !== ((qb.size() < DEPTH) && !clr)) begin
      failures++;
      $display("FAIL brReady got=%b exp=%b", brReady, (qb.size() < DEPTH) && !clr);
    end
    checks++;
    if (aluCount !== 2'(qa.size()) || brCount !== 2'(qb.size())) begin
      failures++;
      $display("FAIL counts got=%0d/%0d exp=%0d/%0d", aluCount, brCount, qa.size(), qb.size());
    end
    checks++;
    if (validBroadcast !== exp_valid) begin
      failures++;
      $display("FAIL validBroadcast got=%b exp=%b", validBroadcast, exp_valid);
    end
    if (exp_valid || exp_zero) begin
      checks++;
      if (robBroadcast !== exp_e.rob || valueBroadcast !== exp_e.val ||
          nextPCBroadcast !== exp_e.pc || mispredictBroadcast !== exp_e.mis ||
          isBranchBroadcast !== exp_e.is_br) begin
        failures++;
        $display("FAIL broadcast got rob=%0d val=%h pc=%h mis=%b br=%b exp rob=%0d val=%h pc=%h mis=%b br=%b",
                 robBroadcast, valueBroadcast, nextPCBroadcast, mispredictBroadcast, isBranchBroadcast,
                 exp_e.rob, exp_e.val, exp_e.pc, exp_e.mis, exp_e.is_br);
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    globalReset = 1'b1; clear = 1'b0; aluValid = 1'b0; brValid = 1'b0;
    aluRob = '0; aluResult = '0; brRob = '0; brResult = '0; brNextPC = '0; brMispredict = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    idle(2);
  endtask

  task automatic test_single_alu();
    cycle(0, 0, 1, 3'd3, 32'h0000_00AA, 0, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic test_tie();
    cycle(0, 0, 1, 3'd1, 32'h1111_0001, 1, 3'd5, 32'h0, 32'h0000_0040, 1);
    idle(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 3'(i), 32'hA000_0000 + 32'(i), 1, 3'(i + 4), 32'hB000_0000 + 32'(i),
            32'h0000_1000 + 32'(4 * i), 1'(i));
    idle(6);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 3'(i), 32'hC000_0000 + 32'(i), 0, 0, 0, 0, 0);
    idle(4);
  endtask

  task automatic test_clear();
    cycle(0, 0, 1, 3'd1, 32'h0000_0011, 1, 3'd2, 32'h0000_0022, 32'h0000_0100, 0);
    cycle(0, 0, 1, 3'd3, 32'h0000_0033, 1, 3'd4, 32'h0000_0044, 32'h0000_0200, 1);
    cycle(0, 1, 1, 3'd7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    idle(4);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 1, 3'(i), 32'h5000_0000 + 32'(i), 1, 3'(i), 32'h6000_0000 + 32'(i), 32'h0000_0800, 0);
    cycle(1, 0, 1, 3'd6, 32'h7777_7777, 1, 3'd6, 32'h8888_8888, 32'h0000_0900, 1);
    cycle(0, 0, 1, 3'd2, 32'h0000_0ABC, 1, 3'd3, 32'h0000_0DEF, 32'h0000_0044, 1);
    idle(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++)
      cycle(($urandom % 97) == 0, ($urandom % 16) == 0,
            1'($urandom), 3'($urandom), $urandom,
            1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom));
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_tie();
    test_back_to_back();
    test_wrap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
